dp_sequencer: RTL

- Multi-cycle control unit that fetches, decodes and sequences every instruction through the 16-bit register-file/FunctionalUnit datapath.
- Owns the 6-bit PC and the instruction register (IR).
- Drives every datapath select and enable: DA/AA/BA, FS, RW, MB, MD, MJ, MM, MK, A_thru, B_thru, PC, PC_prev.
- Arbitrates the single shared memory port between instruction fetch (MM=1) and data access (MM=0) using a req/ack handshake.

---
 rtl/dp_pkg.sv | 72 +++++++
 rtl/dp_if.sv | 56 +++++
 rtl/dp_decoder.sv | 62 ++++++
 rtl/dp_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared definitions for the dp_sequencer control unit: datapath widths,
// opcode values, FunctionalUnit select codes, instruction field positions,
// the FSM state encoding and the static control bundle produced by the
// decoder.
// -----------------------------------------------------------------------------
package dp_pkg;

    localparam int NBIT     = 16;  // instruction / datapath width
    localparam int PC_WIDTH = 6;   // 64-word instruction/data space

    // Opcodes (IR[15:12]); 0x0-0x7 are register-register ALU operations.
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JAL  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // FunctionalUnit selects; ALU opcodes pass op[2:0] straight through.
    localparam logic [2:0] FS_ADD = 3'b000;

    // Instruction field positions.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DA_MSB  = 11;
    localparam int DA_LSB  = 8;
    localparam int AA_MSB  = 7;
    localparam int AA_LSB  = 4;
    localparam int BA_MSB  = 3;
    localparam int BA_LSB  = 0;
    localparam int TGT_MSB = 5;   // jump target is IR[5:0]

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    // Static control set implied by the opcode alone; the sequencer decides
    // in which state each field actually reaches the datapath.
    typedef struct packed {
        logic [2:0] fs;
        logic       mb;
        logic       md;
        logic       mj;
        logic       mk;
        logic       a_thru;
        logic       b_thru;
        logic       writes_reg;
        logic       is_mem;
        logic       is_load;
        logic       is_store;
        logic       is_branch;  // conditional (BZ)
        logic       is_jump;    // unconditional (JMP, JAL)
        logic       is_halt;
    } ctrl_t;

endpackage

// File: rtl/dp_if.sv
// -----------------------------------------------------------------------------
// dp_if
// Bundle between the sequencer and the datapath/memory side.
//   master (sequencer): drives the memory request, the PC pair and every
//                       datapath select/enable; receives instr, mem_ack,
//                       zero_flag.
//   slave  (datapath + memory): the mirror image.
// -----------------------------------------------------------------------------
interface dp_if
    import dp_pkg::*;
#(
    parameter int N_BIT = NBIT,
    parameter int PC_W  = PC_WIDTH
) ();

    // Memory port
    logic [N_BIT-1:0] instr;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;

    // Datapath status
    logic             zero_flag;

    // Program counter pair
    logic [PC_W-1:0]  PC;
    logic [PC_W-1:0]  PC_prev;

    // Register addresses and datapath controls
    logic [3:0]       DA;
    logic [3:0]       AA;
    logic [3:0]       BA;
    logic [2:0]       FS;
    logic             RW;
    logic             MB;
    logic             MD;
    logic             MJ;
    logic             MM;
    logic             MK;
    logic             A_thru;
    logic             B_thru;
    logic             halted;

    modport master (
        input  instr, mem_ack, zero_flag,
        output mem_req, mem_we, PC, PC_prev, DA, AA, BA, FS,
               RW, MB, MD, MJ, MM, MK, A_thru, B_thru, halted
    );

    modport slave (
        output instr, mem_ack, zero_flag,
        input  mem_req, mem_we, PC, PC_prev, DA, AA, BA, FS,
               RW, MB, MD, MJ, MM, MK, A_thru, B_thru, halted
    );

endinterface

// File: rtl/dp_decoder.sv
// -----------------------------------------------------------------------------
// dp_decoder
// Purely combinational opcode decoder.
//   op   in  4       IR[15:12]
//   ctrl out ctrl_t  static control set for that opcode
// -----------------------------------------------------------------------------
module dp_decoder
    import dp_pkg::*;
(
    input  logic [3:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: assigning every field a default before the case means no path
        // leaves a bit unassigned, so no latch is inferred.
        ctrl = '0;
        case (op)
            OP_ADDI: begin
                ctrl.fs         = FS_ADD;
                ctrl.mb         = 1'b1;
                ctrl.mk         = 1'b1;   // DA doubles as the A operand
                ctrl.writes_reg = 1'b1;
            end
            OP_LD: begin
                ctrl.md         = 1'b1;
                ctrl.writes_reg = 1'b1;
                ctrl.is_mem     = 1'b1;
                ctrl.is_load    = 1'b1;
            end
            OP_ST: begin
                ctrl.is_mem     = 1'b1;
                ctrl.is_store   = 1'b1;
            end
            OP_LDI: begin
                ctrl.mb         = 1'b1;
                ctrl.b_thru     = 1'b1;
                ctrl.writes_reg = 1'b1;
            end
            OP_BZ: begin
                ctrl.a_thru     = 1'b1;   // zero_flag reflects R[AA] passed through
                ctrl.is_branch  = 1'b1;
            end
            OP_JMP: begin
                ctrl.is_jump    = 1'b1;
            end
            OP_JAL: begin
                ctrl.mj         = 1'b1;
                ctrl.writes_reg = 1'b1;
                ctrl.is_jump    = 1'b1;
            end
            OP_HALT: begin
                ctrl.is_halt    = 1'b1;
            end
            default: begin              // 0x0-0x7 register-register ALU
                ctrl.fs         = op[2:0];
                ctrl.writes_reg = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dp_sequencer.sv
// -----------------------------------------------------------------------------
// dp_sequencer
// Multi-cycle fetch/decode/execute control unit for the 16-bit register-file
// + FunctionalUnit datapath. Owns PC, PC_prev and IR, arbitrates the single
// memory port between instruction fetch (MM=1) and data access (MM=0).
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   bus    dp_if.master: instr/mem_ack/zero_flag in; mem_req, mem_we, PC,
//          PC_prev, DA/AA/BA, FS, RW, MB, MD, MJ, MM, MK, A_thru, B_thru,
//          halted out
// Zero-wait latency: 3 cycles per instruction (FETCH, DECODE, EXEC or MEM);
// every memory wait cycle adds one.
// -----------------------------------------------------------------------------
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int nBit = NBIT,
    parameter int PC_W = PC_WIDTH
) (
    input  logic clk,
    input  logic reset,
    dp_if.master bus
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_prev_q, pc_prev_d;
    logic [nBit-1:0] ir_q, ir_d;

    ctrl_t           ctrl;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_tgt;
    logic            take_jump;

    dp_decoder u_decoder (
        .op   (ir_q[OP_MSB:OP_LSB]),
        .ctrl (ctrl)
    );

    // Natural PC_W-bit overflow gives the 63 -> 0 wrap.
    assign pc_inc = pc_q + PC_W'(1);

    // BZ target is {DA[1:0], BA}; JMP/JAL target is IR[5:0].
    assign jump_tgt = ctrl.is_branch
                    ? PC_W'({ir_q[DA_LSB+1:DA_LSB], ir_q[BA_MSB:BA_LSB]})
                    : PC_W'(ir_q[TGT_MSB:0]);

    assign take_jump = ctrl.is_jump | (ctrl.is_branch & bus.zero_flag);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_prev_d = pc_prev_q;
        ir_d      = ir_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ack) begin
                    ir_d      = bus.instr;
                    pc_d      = pc_inc;
                    pc_prev_d = pc_inc;   // link address for JAL
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ctrl.is_mem) begin
                    state_d = S_MEM;
                end else if (ctrl.is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // PC update shares the edge with the register write.
                if (take_jump) begin
                    pc_d = jump_tgt;
                end
                state_d = S_FETCH;
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: IR is reset along with the PC pair so DA/AA/BA read 0 and
            // an aborted instruction leaves nothing behind for the next decode.
            state_q   <= S_FETCH;
            pc_q      <= '0;
            pc_prev_q <= '0;
            ir_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_prev_q <= pc_prev_d;
            ir_q      <= ir_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath controls. Everything is gated by reset so the FETCH reset state
    // does not raise mem_req/MM while reset is still held.
    // -------------------------------------------------------------------------
    assign bus.PC      = pc_q;
    assign bus.PC_prev = pc_prev_q;
    assign bus.DA      = ir_q[DA_MSB:DA_LSB];
    assign bus.AA      = ir_q[AA_MSB:AA_LSB];
    assign bus.BA      = ir_q[BA_MSB:BA_LSB];

    always_comb begin
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.FS      = '0;
        bus.RW      = 1'b0;
        bus.MB      = 1'b0;
        bus.MD      = 1'b0;
        bus.MJ      = 1'b0;
        bus.MM      = 1'b0;
        bus.MK      = 1'b0;
        bus.A_thru  = 1'b0;
        bus.B_thru  = 1'b0;
        bus.halted  = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.MM      = 1'b1;
                end
                S_DECODE, S_EXEC: begin
                    // DECODE shows the same selects as EXEC, minus the write,
                    // so the register reads have a full cycle to settle.
                    bus.FS     = ctrl.fs;
                    bus.MB     = ctrl.mb;
                    bus.MD     = ctrl.md;
                    bus.MJ     = ctrl.mj;
                    bus.MK     = ctrl.mk;
                    bus.A_thru = ctrl.a_thru;
                    bus.B_thru = ctrl.b_thru;
                    bus.RW     = (state_q == S_EXEC) && ctrl.writes_reg;
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = ctrl.is_store;
                    // Load data is only valid in the ack cycle.
                    if (ctrl.is_load && bus.mem_ack) begin
                        bus.RW = 1'b1;
                        bus.MD = 1'b1;
                    end
                end
                S_HALT: begin
                    bus.halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
